pixel_writer: RTL

Downstream stage of the triangle filler. Consumes the filler's (x, y, valid, done) pixel stream and applies backpressure through the filler's `ready` input. Clips pixels against the framebuffer, converts each surviving pixel to a linear framebuffer address, and buffers it in a small FIFO. Issues one write request per pixel to the video-memory port and pulses `tri_done` once the triangle is fully written.

---
 rtl/pixel_writer_if.sv | 28 ++
 rtl/pixel_writer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pixel_writer_if.sv
// Pixel stream from the triangle filler and write port towards video memory.
interface pixel_writer_if #(
  parameter int unsigned PIXEL_ADDR_WIDTH = 16,
  parameter int unsigned MEM_ADDR_WIDTH   = 19,
  parameter int unsigned COLOR_WIDTH      = 16
);
  logic [PIXEL_ADDR_WIDTH-1:0] in_x;
  logic [PIXEL_ADDR_WIDTH-1:0] in_y;
  logic                        in_valid;
  logic                        in_done;
  logic                        in_ready;
  logic                        wr_valid;
  logic [MEM_ADDR_WIDTH-1:0]   wr_addr;
  logic [COLOR_WIDTH-1:0]      wr_data;
  logic                        wr_ready;

  // Environment side: filler pixel source plus memory acceptance.
  modport master (
    output in_x, in_y, in_valid, in_done, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data
  );

  // Writer side.
  modport slave (
    input  in_x, in_y, in_valid, in_done, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/pixel_writer.sv
// Clips filler pixels, converts them to linear addresses, buffers them in a
// show-ahead FIFO and issues one memory write per surviving pixel.
module pixel_writer #(
  parameter int unsigned PIXEL_ADDR_WIDTH = 16,
  parameter int unsigned FB_WIDTH         = 640,
  parameter int unsigned FB_HEIGHT        = 480,
  parameter int unsigned MEM_ADDR_WIDTH   = 19,
  parameter int unsigned COLOR_WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [COLOR_WIDTH-1:0] fill_color,
  pixel_writer_if.slave          bus,
  output logic                   busy,
  output logic                   tri_done,
  output logic [31:0]            pix_count,
  output logic [31:0]            clip_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned PROD_W = PIXEL_ADDR_WIDTH + 32;

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0] addr;
    logic [COLOR_WIDTH-1:0]    data;
  } wr_entry_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t             state;
  state_t             state_next;
  logic               armed;
  wr_entry_t          mem [FIFO_DEPTH];
  wr_entry_t          head;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               empty;
  logic               full;
  logic               ready_c;
  logic               accept;
  logic               clipped;
  logic               push;
  logic               pop;
  logic [PROD_W-1:0]  lin_addr;

  // Datapath decode: clipping, linear address and handshakes.
  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign accept   = bus.in_valid && ready_c;
  assign clipped  = (PROD_W'(bus.in_x) >= PROD_W'(FB_WIDTH)) ||
                    (PROD_W'(bus.in_y) >= PROD_W'(FB_HEIGHT));
  assign lin_addr = PROD_W'(bus.in_y) * PROD_W'(FB_WIDTH) + PROD_W'(bus.in_x);
  assign push     = accept && !clipped;
  assign pop      = bus.wr_valid && bus.wr_ready;

  // Show-ahead head of the FIFO drives the memory request directly.
  assign head         = mem[rd_ptr];
  assign bus.wr_valid = !empty;
  assign bus.wr_addr  = head.addr;
  assign bus.wr_data  = head.data;
  assign bus.in_ready = ready_c;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ACTIVE;
      ACTIVE:  if (armed && bus.in_done) state_next = DRAIN;
      DRAIN:   if (empty) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs; done condition blocks acceptance in its own cycle.
  always_comb begin
    ready_c = 1'b0;
    busy    = 1'b0;
    unique case (state)
      ACTIVE: begin
        ready_c = !full && !(armed && bus.in_done);
        busy    = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      default: ;
    endcase
  end

  // Arming ignores a done level left over from the previous triangle.
  always_ff @(posedge clk) begin
    if (reset)                            armed <= 1'b0;
    else if (state == IDLE && start)      armed <= 1'b0;
    else if (state == ACTIVE && !bus.in_done) armed <= 1'b1;
  end

  // Registered completion pulse on the DRAIN -> IDLE edge.
  always_ff @(posedge clk) begin
    if (reset) tri_done <= 1'b0;
    else       tri_done <= (state == DRAIN) && (state_next == IDLE);
  end

  // Per-triangle pixel and clip counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_count  <= '0;
      clip_count <= '0;
    end else if (state == IDLE && start) begin
      pix_count  <= '0;
      clip_count <= '0;
    end else begin
      if (pop)               pix_count  <= pix_count + 32'(1);
      if (accept && clipped) clip_count <= clip_count + 32'(1);
    end
  end

  // Write-buffer storage and pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{addr: MEM_ADDR_WIDTH'(lin_addr), data: fill_color};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule
